// File: rtl/ocm_bus_initiator.sv
// Host-command initiator for the OCM slot bus: FIFO-buffered read/write commands issued one at a time.
// Latency: a command pushed into an empty FIFO raises req one cycle later; ack ends the cycle on the same edge.
// Backpressure: cmd_ready drops while the FIFO is full; the bus side waits on ack (optionally bounded by
// the OCM_INITIATOR_TIMEOUT_EN timeout).
module ocm_bus_initiator #(
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic        clk21m,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wrt,
  input  logic [15:0] cmd_adr,
  input  logic [7:0]  cmd_dat,
  output logic        rsp_valid,
  output logic [7:0]  rsp_dat,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        req,
  output logic        wrt,
  output logic [15:0] adr,
  output logic [7:0]  dbo,
  input  logic        ack,
  input  logic [7:0]  dbi
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

  // Command FIFO: entry is {wrt, adr, dat}; pointers carry an extra wrap bit.
  logic [24:0]              mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2:0] wptr_q, rptr_q;
  logic                     full, empty, push, pop;
  logic [24:0]              head;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        wrt_q, wrt_d;
  logic [15:0] adr_q, adr_d;
  logic [7:0]  dbo_q, dbo_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_dat_q, rsp_dat_d;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_DEPTH_LOG2] != rptr_q[FIFO_DEPTH_LOG2]) &&
                 (wptr_q[FIFO_DEPTH_LOG2-1:0] == rptr_q[FIFO_DEPTH_LOG2-1:0]);
  // A pop in the same cycle does not free a slot for a push while full.
  assign push  = cmd_valid & ~full;
  assign head  = mem_q[rptr_q[FIFO_DEPTH_LOG2-1:0]];

  assign cmd_ready = ~full;
  assign busy      = ~empty | (state_q != ST_IDLE);
  assign req       = req_q;
  assign wrt       = wrt_q;
  assign adr       = adr_q;
  assign dbo       = dbo_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;

`ifdef OCM_INITIATOR_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       rsp_timeout_q, rsp_timeout_d;
  assign rsp_timeout = rsp_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |8'(TIMEOUT_CYCLES);
  assign rsp_timeout = 1'b0;
`endif

  // FIFO storage: contents need no reset, pointers define validity.
  always_ff @(posedge clk21m) begin
    if (push) mem_q[wptr_q[FIFO_DEPTH_LOG2-1:0]] <= {cmd_wrt, cmd_adr, cmd_dat};
  end

  // Next-state and bus-cycle control.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    req_d       = req_q;
    wrt_d       = wrt_q;
    adr_d       = adr_q;
    dbo_d       = dbo_q;
    rsp_valid_d = 1'b0;
    rsp_dat_d   = rsp_dat_q;
`ifdef OCM_INITIATOR_TIMEOUT_EN
    cnt_d         = cnt_q;
    rsp_timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (!empty) begin
          pop                  = 1'b1;
          {wrt_d, adr_d, dbo_d} = head;
          req_d                = 1'b1;
          state_d              = ST_ISSUE;
`ifdef OCM_INITIATOR_TIMEOUT_EN
          cnt_d                = 8'h00;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // req must drop on the acknowledging edge; responders may restart on a held req.
        if (ack) begin
          req_d   = 1'b0;
          state_d = ST_GAP;
          if (!wrt_q) begin
            rsp_valid_d = 1'b1;
            rsp_dat_d   = dbi;
          end
        end
`ifdef OCM_INITIATOR_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          req_d         = 1'b0;
          state_d       = ST_GAP;
          rsp_timeout_d = 1'b1;
          if (!wrt_q) begin
            rsp_valid_d = 1'b1;
            rsp_dat_d   = 8'hFF;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset drops req immediately without waiting for a clock.
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      req_q       <= 1'b0;
      wrt_q       <= 1'b0;
      adr_q       <= 16'h0000;
      dbo_q       <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      req_q       <= req_d;
      wrt_q       <= wrt_d;
      adr_q       <= adr_d;
      dbo_q       <= dbo_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

`ifdef OCM_INITIATOR_TIMEOUT_EN
  // Timeout counter and abort pulse.
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      cnt_q         <= 8'h00;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_ocm_bus_initiator.sv
// Self-checking bench for ocm_bus_initiator: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model (command queue + bus-cycle phase).
// Works with or without OCM_INITIATOR_TIMEOUT_EN; the DUT runs with TIMEOUT_CYCLES = 16.
module tb_ocm_bus_initiator;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  typedef struct packed {
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
  } cmd_t;

  logic        clk21m = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_wrt;
  logic [15:0] cmd_adr;
  logic [7:0]  cmd_dat;
  logic        rsp_valid, rsp_timeout, busy;
  logic [7:0]  rsp_dat;
  logic        req, wrt, ack;
  logic [15:0] adr;
  logic [7:0]  dbo, dbi;

  ocm_bus_initiator #(.FIFO_DEPTH_LOG2(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk21m(clk21m), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wrt(cmd_wrt),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_timeout(rsp_timeout), .busy(busy),
    .req(req), .wrt(wrt), .adr(adr), .dbo(dbo), .ack(ack), .dbi(dbi)
  );

  always #5 clk21m = ~clk21m;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  cmd_t        q[$];
  bit          m_active, m_gap;
  int          hi;
  logic        e_wrt, e_rsp_valid, e_rsp_to;
  logic [15:0] e_adr;
  logic [7:0]  e_dbo, e_rsp_dat;
  bit          last_acc;

  // Responder model.
  bit          resp_en, rnd_delay, rnd_dbi;
  int          cur_delay, r_hi;
  logic [7:0]  fix_dbi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req", 32'(req), 0);
    chk("rst_wrt", 32'(wrt), 0);
    chk("rst_adr", 32'(adr), 0);
    chk("rst_dbo", 32'(dbo), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_dat", 32'(rsp_dat), 0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 0; m_gap = 0; hi = 0; r_hi = 0;
    e_wrt = 0; e_adr = 0; e_dbo = 0;
    e_rsp_valid = 0; e_rsp_to = 0; e_rsp_dat = 0;
    ack = 0;
  endtask

  // One clock: advance the model from inputs seen at the edge, compare, then drive the responder.
  task automatic step();
    bit         a, acc;
    logic [7:0] d;
    int         qb;
    cmd_t       c, h;
    a   = ack;
    d   = dbi;
    qb  = q.size();
    acc = cmd_valid && (qb < DEPTH);
    c   = '{cmd_wrt, cmd_adr, cmd_dat};
    @(posedge clk21m); #1;
    e_rsp_valid = 0;
    e_rsp_to    = 0;
    if (m_active) begin
      if (a) begin
        m_active = 0; m_gap = 1;
        if (!e_wrt) begin e_rsp_valid = 1; e_rsp_dat = d; end
      end
`ifdef OCM_INITIATOR_TIMEOUT_EN
      else if (hi == TO) begin
        m_active = 0; m_gap = 1; e_rsp_to = 1;
        if (!e_wrt) begin e_rsp_valid = 1; e_rsp_dat = 8'hFF; end
      end
`endif
      else hi++;
    end else begin
      m_gap = 0;
      if (qb > 0) begin
        h = q.pop_front();
        e_wrt = h.w; e_adr = h.a; e_dbo = h.d;
        m_active = 1; hi = 1;
      end
    end
    if (acc) q.push_back(c);
    last_acc = acc;

    chk("req", 32'(req), 32'(m_active));
    chk("wrt", 32'(wrt), 32'(e_wrt));
    chk("adr", 32'(adr), 32'(e_adr));
    chk("dbo", 32'(dbo), 32'(e_dbo));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
    chk("rsp_dat", 32'(rsp_dat), 32'(e_rsp_dat));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(e_rsp_to));
    chk("busy", 32'(busy), 32'(q.size() > 0 || m_active || m_gap));
    chk("cmd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));

    if (req) r_hi++; else r_hi = 0;
    if (req && r_hi == 1 && rnd_delay) cur_delay = $urandom_range(1, 5);
    ack = resp_en && req && (r_hi == cur_delay);
    if (ack) dbi = rnd_dbi ? 8'($urandom) : fix_dbi;
  endtask

  task automatic push(input logic w, input logic [15:0] a, input logic [7:0] d);
    cmd_wrt = w; cmd_adr = a; cmd_dat = d; cmd_valid = 1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (last_acc) break;
    end
    if (!last_acc) chk("push_accept_timeout", 0, 1);
    cmd_valid = 0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 0 && !m_active && !m_gap) begin done = 1; break; end
      step();
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    reset = 1; cmd_valid = 0; cmd_wrt = 0; cmd_adr = 0; cmd_dat = 0;
    ack = 0; dbi = 0; fix_dbi = 0;
    resp_en = 1; rnd_delay = 0; rnd_dbi = 0; cur_delay = 1;
    model_reset();
    repeat (2) @(posedge clk21m);
    #1;
    chk_reset_vals();
    reset = 0;

    // Single read, responder acks after 10 req-high cycles.
    cur_delay = 10; fix_dbi = 8'h5A;
    push(1'b0, 16'h9880, 8'h00);
    drain();
    step();
    chk("read_rsp_dat_5a", 32'(rsp_dat), 32'h5A);
    chk("read_busy_idle", 32'(busy), 0);

    // Write burst filling the FIFO; pushes beyond full wait for cmd_ready.
    cur_delay = 1;
    for (int i = 0; i < 8; i++) push(1'b1, 16'h7FF0 + 16'(i), 8'hA0 + 8'(i));
    drain();
    step();

    // Random mixed traffic.
    rnd_delay = 1; rnd_dbi = 1;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) step();
      push(1'($urandom), 16'($urandom), 8'($urandom));
    end
    drain();
    step();
    rnd_delay = 0; rnd_dbi = 0;

`ifdef OCM_INITIATOR_TIMEOUT_EN
    // Missing ack aborts after TO cycles with 8'hFF read data.
    resp_en = 0;
    push(1'b0, 16'h1234, 8'h00);
    drain();
    step();
    chk("timeout_rsp_dat_ff", 32'(rsp_dat), 32'hFF);
    // ack on the timeout edge wins.
    resp_en = 1; cur_delay = TO; fix_dbi = 8'h3C;
    push(1'b0, 16'h1235, 8'h00);
    drain();
    step();
    chk("ack_wins_rsp_dat", 32'(rsp_dat), 32'h3C);
`endif

    // Hung read with two queued entries, then reset mid-ISSUE.
    resp_en = 0;
    push(1'b0, 16'h4000, 8'h00);
    push(1'b1, 16'h4001, 8'h11);
    push(1'b1, 16'h4002, 8'h22);
`ifdef OCM_INITIATOR_TIMEOUT_EN
    repeat (5) step();
`else
    repeat (1000) step();
`endif
    chk("hang_req_high", 32'(req), 1);
    chk("hang_busy", 32'(busy), 1);
    #3;
    reset = 1;
    #1;
    chk_reset_vals();
    model_reset();
    repeat (2) step();
    reset = 0;
    repeat (10) step();
    chk("post_reset_no_req", 32'(req), 0);

    // Fresh command after reset completes normally.
    resp_en = 1; cur_delay = 3; fix_dbi = 8'hC3;
    push(1'b0, 16'hBEEF, 8'h00);
    drain();
    step();
    chk("post_reset_read", 32'(rsp_dat), 32'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
